// File: rtl/pac_fram_pkg.sv
// Shared types and constants for the PAC FRAM access sequencer.
package pac_fram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAct,
        StWrAct,
        StWrHold,
        StWaitEnd,
        StPrech
    } fram_state_e;

    localparam int unsigned WE_CYC_DEF   = 1;
    localparam int unsigned PRE_CYC_DEF  = 1;
    localparam int unsigned HOLD_CYC_DEF = 1;

    localparam logic [15:0] SRAM_LO = 16'h4000;
    localparam logic [15:0] SRAM_HI = 16'h5FFD;

    localparam logic [7:0] UNLOCK_0 = 8'h4D;
    localparam logic [7:0] UNLOCK_1 = 8'h69;

endpackage

// File: rtl/pac_fram_seq_if.sv
// Request/strobe bundle between the slot decoder side and the FRAM sequencer.
interface pac_fram_seq_if;
    logic sram_en;
    logic req_rd;
    logic req_wr;
    logic busy;
    logic wr_done;
    logic FRAM_CEn;
    logic ROM_OEn;
    logic ROM_WEn;

    modport master (
        output sram_en, req_rd, req_wr,
        input  busy, wr_done, FRAM_CEn, ROM_OEn, ROM_WEn
    );

    modport slave (
        input  sram_en, req_rd, req_wr,
        output busy, wr_done, FRAM_CEn, ROM_OEn, ROM_WEn
    );
endinterface

// File: rtl/pac_cyc_timer.sv
// Loadable 3-bit saturating down-counter shared by the write and precharge phases.
module pac_cyc_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when the decrement on this edge lands on (or stays at) zero.
    assign zero = (cnt_q <= 3'd1);

endmodule

// File: rtl/pac_fram_seq.sv
// FRAM access sequencer for the PAC SRAM window: CE precharge, WE-to-CE hold, one access per bus
// cycle. Optional SLT_WAITn stretch for back-to-back accesses when PAC_FRAM_WAIT_EN is defined.
module pac_fram_seq
    import pac_fram_pkg::*;
#(
    parameter int unsigned WE_CYC   = WE_CYC_DEF,
    parameter int unsigned PRE_CYC  = PRE_CYC_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic SLT_CLOCK,
    input  logic SLT_RESETn,
`ifdef PAC_FRAM_WAIT_EN
    output logic SLT_WAITn,
`endif
    pac_fram_seq_if.slave bus
);

    fram_state_e state_q, state_d;
    logic        ce_q, ce_d, oe_q, oe_d, we_q, we_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [2:0]  tmr_val;
    logic        rd_ok, wr_ok;

    assign rd_ok = bus.sram_en && bus.req_rd && !bus.req_wr;
    assign wr_ok = bus.sram_en && bus.req_wr && !bus.req_rd;

    pac_cyc_timer u_timer (
        .clk      (SLT_CLOCK),
        .rst_n    (SLT_RESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = 3'd0;
        tmr_dec  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_ok) begin
                    state_d = StRdAct;
                end else if (wr_ok) begin
                    state_d  = StWrAct;
                    tmr_load = 1'b1;
                    tmr_val  = 3'(WE_CYC);
                end
            end
            StRdAct: begin
                if (!bus.req_rd) begin
                    state_d  = StPrech;
                    tmr_load = 1'b1;
                    tmr_val  = 3'(PRE_CYC);
                end
            end
            StWrAct: begin
                tmr_dec = 1'b1;
                // An early req_wr drop ends the WE pulse at once.
                if (tmr_zero || !bus.req_wr) begin
                    state_d  = StWrHold;
                    tmr_load = 1'b1;
                    tmr_val  = 3'(HOLD_CYC);
                end
            end
            StWrHold: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    done_d = 1'b1;
                    if (bus.req_wr) begin
                        state_d = StWaitEnd;
                    end else begin
                        state_d  = StPrech;
                        tmr_load = 1'b1;
                        tmr_val  = 3'(PRE_CYC);
                    end
                end
            end
            StWaitEnd: begin
                if (!bus.req_wr) begin
                    state_d  = StPrech;
                    tmr_load = 1'b1;
                    tmr_val  = 3'(PRE_CYC);
                end
            end
            StPrech: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ce_d   = !(state_d == StRdAct || state_d == StWrAct || state_d == StWrHold);
        oe_d   = (state_d != StRdAct);
        we_d   = (state_d != StWrAct);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state_q <= StIdle;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PAC_FRAM_WAIT_EN
    logic wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (state_q == StPrech && (rd_ok || wr_ok)) begin
            wait_d = 1'b0;
        end
        if (state_d == StRdAct || state_d == StWrAct) begin
            wait_d = 1'b1;
        end
    end

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            wait_q <= 1'b1;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign SLT_WAITn = wait_q;
`endif

    assign bus.FRAM_CEn = ce_q;
    assign bus.ROM_OEn  = oe_q;
    assign bus.ROM_WEn  = we_q;
    assign bus.busy     = busy_q;
    assign bus.wr_done  = done_q;

    a_no_oe_we: assert property (@(posedge SLT_CLOCK) disable iff (!SLT_RESETn)
        !(!oe_q && !we_q));

endmodule

// File: tb/tb_pac_fram_seq.sv
// Directed bench for pac_fram_seq: default-timing instance plus a PRE_CYC=3 instance.
module tb_pac_fram_seq;

    logic SLT_CLOCK = 1'b0;
    logic SLT_RESETn = 1'b0;
    logic sram_en = 1'b0;
    logic req_rd = 1'b0;
    logic req_wr = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 SLT_CLOCK = ~SLT_CLOCK;

    pac_fram_seq_if bus_a ();
    pac_fram_seq_if bus_b ();

    assign bus_a.sram_en = sram_en;
    assign bus_a.req_rd  = req_rd;
    assign bus_a.req_wr  = req_wr;
    assign bus_b.sram_en = sram_en;
    assign bus_b.req_rd  = req_rd;
    assign bus_b.req_wr  = req_wr;

`ifdef PAC_FRAM_WAIT_EN
    logic wait_a, wait_b;
`endif

    pac_fram_seq dut_a (
        .SLT_CLOCK  (SLT_CLOCK),
        .SLT_RESETn (SLT_RESETn),
`ifdef PAC_FRAM_WAIT_EN
        .SLT_WAITn  (wait_a),
`endif
        .bus        (bus_a.slave)
    );

    pac_fram_seq #(.PRE_CYC(3)) dut_b (
        .SLT_CLOCK  (SLT_CLOCK),
        .SLT_RESETn (SLT_RESETn),
`ifdef PAC_FRAM_WAIT_EN
        .SLT_WAITn  (wait_b),
`endif
        .bus        (bus_b.slave)
    );

    task automatic tick();
        @(posedge SLT_CLOCK);
        #1;
    endtask

    task automatic settle();
        req_rd = 1'b0;
        req_wr = 1'b0;
        sram_en = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy, bus_a.wr_done} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_state got=%b want=11100",
                {bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy, bus_a.wr_done});
        end
        SLT_RESETn = 1'b1;
        settle();
        req_wr = 1'b1;
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_WEn} !== 2'b00) begin
            bad++;
            $display("FAIL reset_pre_wr got=%b want=00", {bus_a.FRAM_CEn, bus_a.ROM_WEn});
        end
        #2 SLT_RESETn = 1'b0;
        #1;
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy} !== 4'b1110) begin
            bad++;
            $display("FAIL reset_async got=%b want=1110",
                {bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy});
        end
        req_wr = 1'b0;
        SLT_RESETn = 1'b1;
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release got=%b want=10", {bus_a.FRAM_CEn, bus_a.busy});
        end
    endtask

    task automatic test_write();
        settle();
        req_wr = 1'b1;
        tick();
        req_wr = 1'b0;
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy} !== 3'b001) begin
            bad++;
            $display("FAIL wr_edge1 got=%b want=001", {bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy});
        end
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_WEn} !== 2'b01) begin
            bad++;
            $display("FAIL wr_edge2 got=%b want=01", {bus_a.FRAM_CEn, bus_a.ROM_WEn});
        end
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.wr_done} !== 2'b11) begin
            bad++;
            $display("FAIL wr_edge3 got=%b want=11", {bus_a.FRAM_CEn, bus_a.wr_done});
        end
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.wr_done} !== 2'b10) begin
            bad++;
            $display("FAIL wr_edge4 got=%b want=10", {bus_a.FRAM_CEn, bus_a.wr_done});
        end
        tick();
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_edge5_busy got=%b want=0", bus_a.busy);
        end
    endtask

    task automatic test_read();
        settle();
        req_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn} !== 3'b001) begin
                bad++;
                $display("FAIL rd_active%0d got=%b want=001", i,
                    {bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn});
            end
        end
        req_rd = 1'b0;
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn} !== 3'b111) begin
            bad++;
            $display("FAIL rd_release got=%b want=111",
                {bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn});
        end
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.busy} !== 2'b10) begin
            bad++;
            $display("FAIL rd_done got=%b want=10", {bus_a.FRAM_CEn, bus_a.busy});
        end
    endtask

    task automatic test_back_to_back();
        int ce_high;
        int wait_low;
        bit started;
        settle();
        ce_high = 0;
        wait_low = 0;
        started = 1'b0;
        req_wr = 1'b1;
        tick();
        req_wr = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_b.FRAM_CEn, bus_b.wr_done} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_wr_end got=%b want=11", {bus_b.FRAM_CEn, bus_b.wr_done});
        end
        ce_high = 1;
        req_rd = 1'b1;
        for (int i = 0; i < 10 && !started; i++) begin
            tick();
`ifdef PAC_FRAM_WAIT_EN
            if (wait_b === 1'b0) wait_low++;
`endif
            if (bus_b.FRAM_CEn === 1'b0) started = 1'b1;
            else ce_high++;
        end
        total++;
        if (!started) begin
            bad++;
            $display("FAIL b2b_timeout got=no_read want=read_start");
        end
        total++;
        if (ce_high != 4) begin
            bad++;
            $display("FAIL b2b_ce_gap got=%0d want=4", ce_high);
        end
        total++;
        if (bus_b.ROM_OEn !== 1'b0) begin
            bad++;
            $display("FAIL b2b_oe got=%b want=0", bus_b.ROM_OEn);
        end
`ifdef PAC_FRAM_WAIT_EN
        total++;
        if (wait_low != 3) begin
            bad++;
            $display("FAIL b2b_wait got=%0d want=3", wait_low);
        end
`endif
        req_rd = 1'b0;
    endtask

    task automatic test_long_write();
        int we_low;
        settle();
        we_low = 0;
        req_wr = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) req_wr = 1'b0;
            if (bus_a.ROM_WEn === 1'b0) we_low++;
            if (i == 3) begin
                total++;
                if ({bus_a.FRAM_CEn, bus_a.wr_done} !== 2'b11) begin
                    bad++;
                    $display("FAIL long_ce_rise got=%b want=11", {bus_a.FRAM_CEn, bus_a.wr_done});
                end
            end
            if (i == 5) begin
                total++;
                if ({bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy} !== 3'b111) begin
                    bad++;
                    $display("FAIL long_wait_end got=%b want=111",
                        {bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy});
                end
            end
        end
        total++;
        if (we_low != 1) begin
            bad++;
            $display("FAIL long_we_cycles got=%0d want=1", we_low);
        end
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL long_idle got=%b want=0", bus_a.busy);
        end
    endtask

    task automatic test_illegal();
        settle();
        req_rd = 1'b1;
        req_wr = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy} !== 4'b1110) begin
            bad++;
            $display("FAIL both_req got=%b want=1110",
                {bus_a.FRAM_CEn, bus_a.ROM_OEn, bus_a.ROM_WEn, bus_a.busy});
        end
        req_rd = 1'b0;
        sram_en = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy} !== 3'b110) begin
            bad++;
            $display("FAIL locked_wr got=%b want=110", {bus_a.FRAM_CEn, bus_a.ROM_WEn, bus_a.busy});
        end
        req_wr = 1'b0;
        sram_en = 1'b1;
        tick();
        req_rd = 1'b1;
        tick();
        sram_en = 1'b0;
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn} !== 2'b00) begin
            bad++;
            $display("FAIL rd_unlock_drop got=%b want=00", {bus_a.FRAM_CEn, bus_a.ROM_OEn});
        end
        req_rd = 1'b0;
        tick();
        total++;
        if ({bus_a.FRAM_CEn, bus_a.ROM_OEn} !== 2'b11) begin
            bad++;
            $display("FAIL rd_unlock_end got=%b want=11", {bus_a.FRAM_CEn, bus_a.ROM_OEn});
        end
        sram_en = 1'b1;
    endtask

    initial begin
        #12;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_long_write();
        test_illegal();
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
